// File: rtl/rr_request_encoder8_pkg.sv
// Shared constants and helpers for the 8-way round-robin request encoder.
package rr_request_encoder8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] RR_PTR_RST = 3'd0;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_request_encoder8_if.sv
// Request/grant bundle between the request sources, the encoder and the index consumer.
interface rr_request_encoder8_if;
    import rr_request_encoder8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             flush;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic [N_REQ-1:0] pending_o;

    modport master (
        input  req, flush, out_ready,
        output out_idx, out_valid, pending_o
    );

    modport slave (
        output req, flush, out_ready,
        input  out_idx, out_valid, pending_o
    );

endinterface

// File: rtl/rr_request_encoder8_pick8.sv
// Combinational round-robin pick: first set bit of cand at or after ptr, wrapping 7 to 0.
module rr_pick8
    import rr_request_encoder8_pkg::*;
(
    input  logic [N_REQ-1:0] cand_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] pick_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotating right by ptr puts the highest-priority candidate at bit 0.
    assign rot = (cand_i >> ptr_i) | (cand_i << (4'd8 - {1'b0, ptr_i}));

    always_comb begin
        off   = '0;
        any_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

    assign pick_o = off + ptr_i;

endmodule

// File: rtl/rr_request_encoder8.sv
// Sticky 8-source request collector with round-robin selection onto a registered valid/ready index slot.
module rr_request_encoder8
    import rr_request_encoder8_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rr_request_encoder8_if.master bus
);

    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;

    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             any;
    logic             slot_free;

    assign cand      = pending_q | bus.req;
    assign slot_free = !out_valid_q || bus.out_ready;

    rr_pick8 u_pick (
        .cand_i (cand),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    always_comb begin
        pending_d   = cand;
        rr_ptr_d    = rr_ptr_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
        end else if (slot_free) begin
            if (any) begin
                // A request on the picked bit this cycle is absorbed by this grant.
                out_idx_d   = pick;
                out_valid_d = 1'b1;
                pending_d   = cand & ~onehot8(pick);
                rr_ptr_d    = pick + 3'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            rr_ptr_q    <= RR_PTR_RST;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pending_o = pending_q;

endmodule
